// File: rtl/spi_resp_pkg.sv
// Shared types and command codes for the display-controller SPI responder.
package spi_resp_pkg;

  localparam logic [7:0] CMD_RDDID = 8'h04;
  localparam logic [7:0] CMD_NOP   = 8'h00;

  typedef struct packed {
    logic       is_data;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {
    RESP_IDLE,
    RESP_SHIFT
  } resp_state_t;

endpackage

// File: rtl/spi_resp_fifo.sv
// Show-ahead FIFO of received SPI entries; a push into a full FIFO is accepted only alongside a pop.
module spi_resp_fifo
  import spi_resp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  rx_entry_t din,
  output rx_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_display_responder.sv
// SPI mode-0 responder modelling the LCD controller: queues tagged bytes, answers Read-ID.
// Optional SPI_RESP_TRACE_EN prints every received byte and each overflow drop in simulation.
//   state      | meaning
//   RESP_IDLE  | no response in progress, spi_miso = 0, Read-ID may be recognised
//   RESP_SHIFT | shifting {dummy, DISPLAY_ID} out MSB first on spi_miso
module spi_display_responder
  import spi_resp_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] DISPLAY_ID = 24'h009341
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_csb,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  output logic        spi_miso,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_is_data,
  output logic        rx_overflow,
  input  logic        clear_overflow,
  output logic [15:0] byte_count
);

  logic        clk_s1, clk_s2, clk_d;
  logic        csb_s1, csb_s2;
  logic        mosi_s1, mosi_s2;
  logic        dc_s1, dc_s2;
  logic        spi_rise, spi_fall;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  byte_val;
  logic        byte_done;

  rx_entry_t   push_entry;
  rx_entry_t   head_entry;
  logic        fifo_full, fifo_empty, fifo_pop, drop;

  resp_state_t state, state_nxt;
  logic [31:0] resp_sr;
  logic [4:0]  resp_cnt;
  logic        rise_seen;
  logic        resp_load, resp_shift, resp_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_d   <= 1'b0;
      csb_s1  <= 1'b1;
      csb_s2  <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      dc_s1   <= 1'b0;
      dc_s2   <= 1'b0;
    end else begin
      clk_s1  <= spi_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      csb_s1  <= spi_csb;
      csb_s2  <= csb_s1;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      dc_s1   <= spi_dc;
      dc_s2   <= dc_s1;
    end
  end

  assign spi_rise = clk_s2 && !clk_d;
  assign spi_fall = !clk_s2 && clk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (csb_s2) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (spi_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[5:0], mosi_s2};
    end
  end

  // The 8th bit goes straight into the entry so the push lands on the same clk as the edge.
  assign byte_done          = spi_rise && !csb_s2 && (bit_cnt == 3'd7);
  assign byte_val           = {rx_shift, mosi_s2};
  assign push_entry.is_data = dc_s2;
  assign push_entry.data    = byte_val;

  assign fifo_pop = rx_valid && rx_ready;
  assign drop     = byte_done && fifo_full && !fifo_pop;

  spi_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_done),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid   = !fifo_empty;
  assign rx_data    = head_entry.data;
  assign rx_is_data = head_entry.is_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overflow <= 1'b0;
      byte_count  <= '0;
    end else begin
      if (clear_overflow) rx_overflow <= 1'b0;
      else if (drop)      rx_overflow <= 1'b1;
      if (byte_done) byte_count <= byte_count + 16'd1;
    end
  end

  // Read-ID response FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESP_IDLE:  if (resp_load) state_nxt = RESP_SHIFT;
      RESP_SHIFT: if (csb_s2 || resp_last) state_nxt = RESP_IDLE;
      default:    state_nxt = RESP_IDLE;
    endcase
  end

  always_comb begin
    resp_load  = (state == RESP_IDLE) && byte_done && !dc_s2 && (byte_val == CMD_RDDID);
    resp_shift = (state == RESP_SHIFT) && !csb_s2 && spi_fall && rise_seen;
    resp_last  = resp_shift && (resp_cnt == 5'd0);
    spi_miso   = (state == RESP_SHIFT) && !csb_s2 && resp_sr[31];
  end

  // rise_seen keeps the falling edge that closes the command byte from shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sr   <= '0;
      resp_cnt  <= '0;
      rise_seen <= 1'b0;
    end else if (resp_load) begin
      resp_sr   <= {8'h00, DISPLAY_ID};
      resp_cnt  <= 5'd31;
      rise_seen <= 1'b0;
    end else if (resp_shift) begin
      resp_sr   <= {resp_sr[30:0], 1'b0};
      resp_cnt  <= resp_cnt - 5'd1;
      rise_seen <= 1'b0;
    end else if (state == RESP_SHIFT && spi_rise && !csb_s2) begin
      rise_seen <= 1'b1;
    end
  end

`ifdef SPI_RESP_TRACE_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && byte_done) begin
      if (dc_s2) $display("DAT 0x%02h", byte_val);
      else       $display("CMD 0x%02h", byte_val);
      if (drop)  $display("WARNING: spi_display_responder rx FIFO full, dropped 0x%02h", byte_val);
    end
  end
`endif
`else
  // Trace disabled: received bytes are only visible through the FIFO.
`endif

endmodule

// File: doc/spi_display_responder.md
Name: spi_display_responder

Overview:
- SPI mode-0 peripheral (responder) model of the LCD display controller, i.e. the far end of the display SPI bus driven by the CPU system's SPI initiator.
- Oversamples spi_clk, spi_csb, spi_mosi and the data/command line in the clk domain, assembles bytes MSB-first and tags each one as command or data.
- Queues tagged bytes in a FIFO for the bench or a frame-capture block; answers the Read-ID command on spi_miso.
- Used in system-level simulation and for on-board loopback.

Parameters:
- FIFO_DEPTH, 8, number of received-byte entries; power of two, at least 2.
- DISPLAY_ID, 24'h009341, ID returned by the Read-ID command, MSB byte first.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- spi_clk  input  1  SPI clock from initiator; idles low
- spi_csb  input  1  chip select, active low
- spi_mosi  input  1  initiator-to-responder data
- spi_dc  input  1  data_commandb: 1 = data, 0 = command
- spi_miso  output  1  responder-to-initiator data
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer pops the head entry when rx_valid && rx_ready
- rx_data  output  8  head-entry byte
- rx_is_data  output  1  head-entry spi_dc tag
- rx_overflow  output  1  sticky: a byte was dropped because the FIFO was full
- clear_overflow  input  1  synchronous clear of rx_overflow
- byte_count  output  16  received bytes since reset; wraps at 2^16

Behaviour:
- Reset: rst is asynchronous, active-high. All outputs go to 0, FIFO empties, bit counter clears, response goes idle. Synchronizers reset to spi_csb=1 and spi_clk=0.
- Synchronization: each SPI input passes through a 2-flop synchronizer. Edges are detected on the synchronized spi_clk. Requirement: spi_clk high and low phases each last at least 4 clk periods.
- csb high: bit counter and partial byte clear immediately, response goes idle, spi_miso=0. spi_miso is never tristated.
- Receive path:
  - On each spi_clk rising edge while csb is low, shift in mosi (MSB first) and increment the 3-bit counter.
  - On the 8th bit, form the entry {spi_dc sampled at that edge, byte} and push it; byte_count increments.
  - rx_valid asserts exactly 3 clk cycles after the 8th rising edge arrives at the pin.
- FIFO:
  - Show-ahead: rx_data and rx_is_data are valid whenever rx_valid=1.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - Push while full (and no pop that cycle): the byte is dropped, rx_overflow is set, and byte_count still increments.
  - clear_overflow takes priority over a same-cycle set.
- Read-ID response:
  - Triggered when a completed byte has dc=0 and value CMD_RDDID (8'h04).
  - At the command's 8th rising edge, load the 32-bit shift register {8'h00 dummy, DISPLAY_ID}. spi_miso = shift register MSB.
  - Shift left on each spi_clk falling edge that follows a rising edge counted in the response phase. The falling edge that ends the command byte does not shift.
  - After 32 response bits, or on csb high, the response goes idle and spi_miso=0.
  - A new command byte arriving during a response does not restart it; a Read-ID is only recognised while the response is idle.
  - Bytes clocked in during the response are received and queued normally.
- Partial byte at csb rising: discarded, never queued.

Optional Feature:
- Macro SPI_RESP_TRACE_EN.
- Defined: on every push, simulation prints "CMD 0xNN" or "DAT 0xNN", and a warning on each overflow drop. The print logic is enclosed so that synthesis ignores it.
- Undefined: no prints; the RTL is otherwise identical.

Decomposition:
- Package spi_resp_pkg contains:
  - the localparams CMD_RDDID=8'h04 and CMD_NOP=8'h00;
  - the typedef rx_entry_t, a packed struct of is_data (1 bit) and data (8 bits).
- Sub-module spi_resp_fifo: synchronous show-ahead FIFO of rx_entry_t with parameter DEPTH. Ports: push, pop, full, empty.
- The top level holds the synchronizers, edge detection, receive shifter, response shifter and counters.

Test Plan:
- Reset: assert rst mid-transfer, after 3 bits of a byte → all outputs 0 immediately. After release, a fresh 0x2A is received correctly.
- Command: csb low, dc=0, send 0x2A → rx_valid rises 3 clk after the 8th rising edge, rx_data=0x2A, rx_is_data=0, byte_count=1.
- Data: dc=1, send 0x12 then 0x34 back-to-back with rx_ready=1 → pops occur in order 0x12, 0x34, both with is_data=1; byte_count=2.
- Read-ID: send 0x04 with dc=0, then four 0x00 bytes with dc=1 → initiator samples miso bytes 0x00, 0x00, 0x93, 0x41; spi_miso=0 afterwards. Five entries are queued.
- Abort: send 5 bits of 0xFF, raise csb, lower csb, send 0x55 → only 0x55 is queued; byte_count=1.
- Overflow: rx_ready=0, send 9 bytes 0x01..0x09 → 8 entries 0x01..0x08 are queued, rx_overflow=1, byte_count=9. Pulse clear_overflow → rx_overflow=0. A same-cycle set and clear leaves rx_overflow=0.
